regfile_fwd: RTL and testbench

- Architectural GPR file for the 5-stage MIPS core; sink end of the WB-to-RF write bus.
- Consumes the 38-bit write bundle {rf_we, rf_waddr[4:0], rf_wdata[31:0]} that WB drives.
- Serves the two ID-stage read ports, with priority bypass from the EX, MEM and WB result taps.
- Raises a load-use stall request toward the stall controller and counts stall cycles for performance debug.

---
 rtl/regfile_fwd_pkg.sv | 40 ++++
 rtl/regfile_fwd_if.sv | 54 +++++
 rtl/regfile_fwd_fwd_mux.sv | 52 +++++
 rtl/regfile_fwd.sv | 105 ++++++++++
 tb/tb_regfile_fwd.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_fwd_pkg.sv
// Shared constants, bus-layout helpers and types for the GPR file with
// forwarding. Imported by the interface, the top and the bypass selector.
package regfile_fwd_pkg;

    // Default geometry of the architectural register file.
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_CNT_W  = 32;

    // Register index of $0; reads of it always return zero.
    localparam int REG_ZERO = 0;

    // Width of the WB-to-RF write bundle {we, waddr, wdata} at default geometry.
    localparam int WB_TO_RF_WD = 1 + DEF_ADDR_W + DEF_DATA_W;

    // Width of the write bundle for an arbitrary geometry.
    function automatic int wb_bus_wd(input int aw, input int dw);
        return 1 + aw + dw;
    endfunction

    // Bit position of the write-enable flag inside the bundle.
    function automatic int wb_we_pos(input int aw, input int dw);
        return aw + dw;
    endfunction

    // LSB position of the write address field inside the bundle.
    function automatic int wb_waddr_lsb(input int dw);
        return dw;
    endfunction

    // Which source a read port ends up returning.
    typedef enum logic [2:0] {
        SRC_ZERO = 3'd0,
        SRC_EX   = 3'd1,
        SRC_MEM  = 3'd2,
        SRC_WB   = 3'd3,
        SRC_ARR  = 3'd4
    } fwd_src_t;

endpackage

// File: rtl/regfile_fwd_if.sv
// Bundle of the pipeline-facing signals of the register file: WB write bus,
// the two ID read ports, the EX/MEM result taps and the hazard outputs.
interface regfile_fwd_if
    import regfile_fwd_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
);
    // WB stage write bundle {we, waddr, wdata}
    logic [wb_bus_wd(ADDR_W, DATA_W)-1:0] wb_to_rf_bus;

    // ID read ports
    logic [ADDR_W-1:0] rs_raddr;
    logic [ADDR_W-1:0] rt_raddr;
    logic              rs_used;
    logic              rt_used;

    // EX result tap
    logic              ex_we;
    logic [ADDR_W-1:0] ex_waddr;
    logic [DATA_W-1:0] ex_wdata;
    logic              ex_is_load;

    // MEM result tap
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // Results back to ID and the stall controller
    logic [DATA_W-1:0] rs_rdata;
    logic [DATA_W-1:0] rt_rdata;
    logic              stall_req;
    logic [CNT_W-1:0]  lu_stall_cnt;

    // Pipeline side: drives the requests and taps, consumes the results.
    modport master (
        output wb_to_rf_bus,
        output rs_raddr, rt_raddr, rs_used, rt_used,
        output ex_we, ex_waddr, ex_wdata, ex_is_load,
        output mem_we, mem_waddr, mem_wdata,
        input  rs_rdata, rt_rdata, stall_req, lu_stall_cnt
    );

    // Register file side.
    modport slave (
        input  wb_to_rf_bus,
        input  rs_raddr, rt_raddr, rs_used, rt_used,
        input  ex_we, ex_waddr, ex_wdata, ex_is_load,
        input  mem_we, mem_waddr, mem_wdata,
        output rs_rdata, rt_rdata, stall_req, lu_stall_cnt
    );

endinterface

// File: rtl/regfile_fwd_fwd_mux.sv
// Per-read-port bypass selector. Picks the youngest producer of the
// requested index: EX, then MEM, then the WB write in flight, then the
// stored array value. Index $0 always yields zero.
module fwd_mux
    import regfile_fwd_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [ADDR_W-1:0] i_idx,
    input  logic              i_ex_we,
    input  logic [ADDR_W-1:0] i_ex_waddr,
    input  logic [DATA_W-1:0] i_ex_wdata,
    input  logic              i_mem_we,
    input  logic [ADDR_W-1:0] i_mem_waddr,
    input  logic [DATA_W-1:0] i_mem_wdata,
    input  logic              i_wb_we,
    input  logic [ADDR_W-1:0] i_wb_waddr,
    input  logic [DATA_W-1:0] i_wb_wdata,
    input  logic [DATA_W-1:0] i_arr_data,
    output logic [DATA_W-1:0] o_data
);

    fwd_src_t w_src;

    // Strict priority decision: $0 first, then the youngest matching stage.
    always_comb begin
        w_src = SRC_ARR;
        if (i_idx == ADDR_W'(REG_ZERO)) begin
            w_src = SRC_ZERO;
        end else if (i_ex_we && (i_ex_waddr == i_idx)) begin
            w_src = SRC_EX;
        end else if (i_mem_we && (i_mem_waddr == i_idx)) begin
            w_src = SRC_MEM;
        end else if (i_wb_we && (i_wb_waddr == i_idx)) begin
            w_src = SRC_WB;
        end
    end

    // Data steering for the chosen source.
    always_comb begin
        o_data = i_arr_data;
        case (w_src)
            SRC_ZERO: o_data = '0;
            SRC_EX:   o_data = i_ex_wdata;
            SRC_MEM:  o_data = i_mem_wdata;
            SRC_WB:   o_data = i_wb_wdata;
            default:  o_data = i_arr_data;
        endcase
    end

endmodule

// File: rtl/regfile_fwd.sv
// Architectural GPR file of the 5-stage core. Sinks the WB write bundle,
// serves the two ID read ports through EX/MEM/WB bypass, flags load-use
// hazards to the stall controller and counts stalled cycles for debug.
module regfile_fwd
    import regfile_fwd_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        resetn,
    regfile_fwd_if.slave rf
);

    localparam int NREG   = 1 << ADDR_W;
    localparam int WE_POS = wb_we_pos(ADDR_W, DATA_W);
    localparam int WA_LSB = wb_waddr_lsb(DATA_W);

    // Decoded WB write bundle
    logic              w_wb_we;
    logic [ADDR_W-1:0] w_wb_waddr;
    logic [DATA_W-1:0] w_wb_wdata;
    logic              w_wb_commit;

    assign w_wb_we     = rf.wb_to_rf_bus[WE_POS];
    assign w_wb_waddr  = rf.wb_to_rf_bus[WA_LSB +: ADDR_W];
    assign w_wb_wdata  = rf.wb_to_rf_bus[0 +: DATA_W];
    // $0 is never written, so its entry stays at the reset value of zero.
    assign w_wb_commit = w_wb_we && (w_wb_waddr != ADDR_W'(REG_ZERO));

    // Register storage; needs a full asynchronous clear, so it is flops.
    logic [DATA_W-1:0] r_regs [NREG];

    // Commit the WB write; reset clears every entry and drops any write.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_commit) begin
            r_regs[w_wb_waddr] <= w_wb_wdata;
        end
    end

    // Read ports: index 0 is rs, index 1 is rt.
    logic [1:0][ADDR_W-1:0] w_raddr;
    logic [1:0][DATA_W-1:0] w_rdata;

    assign w_raddr[0] = rf.rs_raddr;
    assign w_raddr[1] = rf.rt_raddr;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            fwd_mux #(
                .ADDR_W (ADDR_W),
                .DATA_W (DATA_W)
            ) u_fwd_mux (
                .i_idx       (w_raddr[gi]),
                .i_ex_we     (rf.ex_we),
                .i_ex_waddr  (rf.ex_waddr),
                .i_ex_wdata  (rf.ex_wdata),
                .i_mem_we    (rf.mem_we),
                .i_mem_waddr (rf.mem_waddr),
                .i_mem_wdata (rf.mem_wdata),
                .i_wb_we     (w_wb_we),
                .i_wb_waddr  (w_wb_waddr),
                .i_wb_wdata  (w_wb_wdata),
                .i_arr_data  (r_regs[w_raddr[gi]]),
                .o_data      (w_rdata[gi])
            );
        end
    endgenerate

    assign rf.rs_rdata = w_rdata[0];
    assign rf.rt_rdata = w_rdata[1];

    // Load-use hazard: a load in EX produces a register that ID consumes now.
    logic w_rs_hit;
    logic w_rt_hit;
    logic w_stall;

    assign w_rs_hit = rf.rs_used && (rf.rs_raddr == rf.ex_waddr);
    assign w_rt_hit = rf.rt_used && (rf.rt_raddr == rf.ex_waddr);
    assign w_stall  = rf.ex_we && rf.ex_is_load
                    && (rf.ex_waddr != ADDR_W'(REG_ZERO))
                    && (w_rs_hit || w_rt_hit);

    assign rf.stall_req = w_stall;

    // Saturating count of stalled cycles; holds at all-ones instead of wrapping.
    logic [CNT_W-1:0] r_lu_stall_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_lu_stall_cnt <= '0;
        end else if (w_stall && (r_lu_stall_cnt != {CNT_W{1'b1}})) begin
            r_lu_stall_cnt <= r_lu_stall_cnt + CNT_W'(1);
        end
    end

    assign rf.lu_stall_cnt = r_lu_stall_cnt;

endmodule

// File: tb/tb_regfile_fwd.sv
// Directed bench for regfile_fwd: expected values are queued when the
// stimulus is applied and popped against the DUT outputs once they settle.
module tb_regfile_fwd;
    import regfile_fwd_pkg::*;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int CW = 3;

    logic clk;
    logic resetn;

    regfile_fwd_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) rf_if ();

    regfile_fwd #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .rf     (rf_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observable kinds
    localparam int K_RS  = 0;
    localparam int K_RT  = 1;
    localparam int K_STL = 2;
    localparam int K_CNT = 3;

    typedef struct {
        int          kind;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            K_RS:    return rf_if.rs_rdata;
            K_RT:    return rf_if.rt_rdata;
            K_STL:   return {31'd0, rf_if.stall_req};
            default: return {29'd0, rf_if.lu_stall_cnt};
        endcase
    endfunction

    task automatic exp_push(input int kind, input logic [31:0] v, input string tag);
        exp_t e;
        e.kind = kind;
        e.val  = v;
        e.tag  = tag;
        sb_q.push_back(e);
    endtask

    // Let combinational outputs settle, then drain the scoreboard.
    task automatic check_pending();
        exp_t        e;
        logic [31:0] obs;
        #1;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            obs = observe(e.kind);
            checks++;
            assert (obs === e.val)
            else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
            $display("[%0t] check %s observed=%h", $time, e.tag, obs);
        end
    endtask

    task automatic wb(input logic we, input logic [4:0] a, input logic [31:0] d);
        rf_if.wb_to_rf_bus = {we, a, d};
    endtask

    task automatic ex(input logic we, input logic [4:0] a, input logic [31:0] d, input logic ld);
        rf_if.ex_we      = we;
        rf_if.ex_waddr   = a;
        rf_if.ex_wdata   = d;
        rf_if.ex_is_load = ld;
    endtask

    task automatic mem(input logic we, input logic [4:0] a, input logic [31:0] d);
        rf_if.mem_we    = we;
        rf_if.mem_waddr = a;
        rf_if.mem_wdata = d;
    endtask

    task automatic idle();
        wb(1'b0, 5'd0, 32'd0);
        ex(1'b0, 5'd0, 32'd0, 1'b0);
        mem(1'b0, 5'd0, 32'd0);
        rf_if.rs_raddr = '0;
        rf_if.rt_raddr = '0;
        rf_if.rs_used  = 1'b0;
        rf_if.rt_used  = 1'b0;
    endtask

    // Advance past the next rising edge; inputs are then driven mid-cycle.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Hard bound on run time.
    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        resetn = 1'b0;

        // Reset state, including an edge while held in reset
        rf_if.rs_raddr = 5'd5;
        rf_if.rt_raddr = 5'd31;
        #3;
        exp_push(K_RS, 32'd0, "rst_rs");
        exp_push(K_RT, 32'd0, "rst_rt");
        exp_push(K_STL, 32'd0, "rst_stall");
        exp_push(K_CNT, 32'd0, "rst_cnt");
        check_pending();
        next();
        @(negedge clk);
        resetn = 1'b1;
        next();

        // First write after reset: same-cycle bypass, then array readback
        wb(1'b1, 5'd5, 32'h1234_5678);
        rf_if.rs_raddr = 5'd5;
        exp_push(K_RS, 32'h1234_5678, "wb5_bypass");
        check_pending();
        next();
        idle();
        rf_if.rs_raddr = 5'd5;
        exp_push(K_RS, 32'h1234_5678, "wb5_array");
        check_pending();

        // $0 protection against every tap
        wb(1'b1, 5'd0, 32'hFFFF_FFFF);
        ex(1'b1, 5'd0, 32'hAAAA_AAAA, 1'b0);
        mem(1'b1, 5'd0, 32'hAAAA_AAAA);
        rf_if.rs_raddr = 5'd0;
        rf_if.rt_raddr = 5'd0;
        exp_push(K_RS, 32'd0, "zero_rs_same");
        exp_push(K_RT, 32'd0, "zero_rt_same");
        check_pending();
        next();
        idle();
        exp_push(K_RS, 32'd0, "zero_rs_next");
        check_pending();

        // Priority EX > MEM > WB > array
        ex(1'b1, 5'd3, 32'h1, 1'b0);
        mem(1'b1, 5'd3, 32'h2);
        wb(1'b1, 5'd3, 32'h3);
        rf_if.rs_raddr = 5'd3;
        exp_push(K_RS, 32'h1, "prio_ex");
        check_pending();
        ex(1'b0, 5'd3, 32'h1, 1'b0);
        exp_push(K_RS, 32'h2, "prio_mem");
        check_pending();
        mem(1'b0, 5'd3, 32'h2);
        exp_push(K_RS, 32'h3, "prio_wb");
        check_pending();
        next();
        idle();
        rf_if.rs_raddr = 5'd3;
        exp_push(K_RS, 32'h3, "prio_array");
        check_pending();

        // Same-cycle write-through over a stale entry
        wb(1'b1, 5'd7, 32'h0000_DEAD);
        next();
        wb(1'b1, 5'd7, 32'h0000_BEEF);
        rf_if.rt_raddr = 5'd7;
        exp_push(K_RT, 32'h0000_BEEF, "wt_rt");
        check_pending();
        next();
        idle();
        rf_if.rt_raddr = 5'd7;
        exp_push(K_RT, 32'h0000_BEEF, "wt_array");
        check_pending();

        // EX and WB on the same index: EX wins the read, WB still commits
        ex(1'b1, 5'd4, 32'h44, 1'b0);
        wb(1'b1, 5'd4, 32'h55);
        rf_if.rs_raddr = 5'd4;
        exp_push(K_RS, 32'h44, "exwb_read");
        check_pending();
        next();
        idle();
        rf_if.rs_raddr = 5'd4;
        exp_push(K_RS, 32'h55, "exwb_commit");
        check_pending();
        // Disabled taps are ignored even when their address matches
        ex(1'b0, 5'd4, 32'h99, 1'b0);
        mem(1'b0, 5'd4, 32'h98);
        wb(1'b0, 5'd4, 32'h97);
        exp_push(K_RS, 32'h55, "we0_ignored");
        check_pending();
        next();
        idle();

        // Load-use hazard equation, all within one cycle
        ex(1'b1, 5'd9, 32'h0, 1'b1);
        rf_if.rs_raddr = 5'd9;
        rf_if.rs_used  = 1'b1;
        exp_push(K_STL, 32'd1, "lu_rs");
        check_pending();
        rf_if.rs_used = 1'b0;
        exp_push(K_STL, 32'd0, "lu_rs_unused");
        check_pending();
        rf_if.rt_raddr = 5'd9;
        rf_if.rt_used  = 1'b1;
        exp_push(K_STL, 32'd1, "lu_rt");
        check_pending();
        ex(1'b1, 5'd9, 32'h0, 1'b0);
        exp_push(K_STL, 32'd0, "lu_not_load");
        check_pending();
        ex(1'b1, 5'd0, 32'h0, 1'b1);
        rf_if.rs_raddr = 5'd0;
        rf_if.rs_used  = 1'b1;
        rf_if.rt_raddr = 5'd0;
        exp_push(K_STL, 32'd0, "lu_zero_dst");
        check_pending();
        idle();
        next();
        exp_push(K_CNT, 32'd0, "cnt_idle");
        check_pending();

        // Hold the hazard: 4 stalled edges, then saturate at 7
        ex(1'b1, 5'd9, 32'h0, 1'b1);
        rf_if.rs_raddr = 5'd9;
        rf_if.rs_used  = 1'b1;
        repeat (4) next();
        exp_push(K_STL, 32'd1, "hold_stall");
        exp_push(K_CNT, 32'd4, "cnt_4");
        check_pending();
        repeat (3) next();
        exp_push(K_CNT, 32'd7, "cnt_7");
        check_pending();
        repeat (3) next();
        exp_push(K_CNT, 32'd7, "cnt_sat");
        check_pending();
        idle();
        next();

        // Asynchronous reset mid-cycle clears array and counter at once
        rf_if.rs_raddr = 5'd3;
        exp_push(K_RS, 32'h3, "pre_rst_rs");
        check_pending();
        #2;
        resetn = 1'b0;
        exp_push(K_RS, 32'd0, "async_rs");
        exp_push(K_CNT, 32'd0, "async_cnt");
        check_pending();
        // A write presented across an edge in reset must be dropped
        wb(1'b1, 5'd10, 32'h77);
        next();
        idle();
        @(negedge clk);
        resetn = 1'b1;
        next();
        rf_if.rs_raddr = 5'd10;
        exp_push(K_RS, 32'd0, "dropped_wr");
        check_pending();
        // First edge after release behaves normally
        wb(1'b1, 5'd10, 32'h88);
        next();
        idle();
        rf_if.rs_raddr = 5'd10;
        rf_if.rt_raddr = 5'd5;
        exp_push(K_RS, 32'h88, "post_rst_wr");
        exp_push(K_RT, 32'd0, "post_rst_cleared");
        exp_push(K_CNT, 32'd0, "post_rst_cnt");
        check_pending();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
